// File: rtl/kf_bus_initiator.sv
// rtl/kf_bus_initiator.sv - timed chip-select/strobe bus initiator for a byte-wide peripheral
// Bus outputs are registered from the next-state decode so no host input reaches them combinationally.
module kf_bus_initiator #(
  parameter int unsigned SETUP_CYCLES    = 1,
  parameter int unsigned PULSE_CYCLES    = 2,
  parameter int unsigned HOLD_CYCLES     = 1,
  parameter int unsigned RECOVERY_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       req_write,
  input  logic [1:0] req_address,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] read_data,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic [1:0] address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable,
  input  logic [7:0] data_bus_in
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_e;

  localparam logic [7:0] SETUP_LD = 8'((SETUP_CYCLES == 0) ? 0 : SETUP_CYCLES - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] REC_LD   = 8'((RECOVERY_CYCLES == 0) ? 0 : RECOVERY_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [1:0] address_q, address_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done_q, done_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       oe_q, oe_d;
  logic       accept;
  logic       in_cycle;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: accept = req;
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = STROBE;
          cnt_d   = PULSE_LD;
        end else cnt_d = cnt_q - 8'd1;
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
          if (!wr_q) rdata_d = data_bus_in;
        end else cnt_d = cnt_q - 8'd1;
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          done_d = 1'b1;
          if (RECOVERY_CYCLES != 0) begin
            state_d = RECOVER;
            cnt_d   = REC_LD;
          end else begin
            // With no recovery the last hold edge doubles as an IDLE sample point,
            // so a pending request starts the next cycle without a CS# gap.
            state_d = IDLE;
            accept  = req;
          end
        end else cnt_d = cnt_q - 8'd1;
      end
      RECOVER: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else cnt_d = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      wr_d      = req_write;
      address_d = req_address;
      wdata_d   = req_data;
      if (SETUP_CYCLES != 0) begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
      end else begin
        state_d = STROBE;
        cnt_d   = PULSE_LD;
      end
    end
    in_cycle = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d   = !in_cycle;
    rd_n_d   = !((state_d == STROBE) && !wr_d);
    wr_n_d   = !((state_d == STROBE) && wr_d);
    oe_d     = in_cycle && wr_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      wr_q      <= 1'b0;
      address_q <= 2'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      done_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      oe_q      <= oe_d;
    end
  end

  assign busy                = (state_q != IDLE);
  assign done                = done_q;
  assign read_data           = rdata_q;
  assign chip_select_n       = cs_n_q;
  assign read_enable_n       = rd_n_q;
  assign write_enable_n      = wr_n_q;
  assign address             = address_q;
  assign data_bus_out        = wdata_q;
  assign data_bus_out_enable = oe_q;

endmodule

// File: doc/kf_bus_initiator.md
KF_BUS_INITIATOR -- requirements
Module: kf_bus_initiator

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 1, cycles CS#/address valid before strobe fall (0..255).
REQ-002 SHALL have parameter PULSE_CYCLES, default 2, strobe low width in cycles (1..255).
REQ-003 SHALL have parameter HOLD_CYCLES, default 1, cycles CS#/address/data held after strobe rise (1..255).
REQ-004 SHALL have parameter RECOVERY_CYCLES, default 1, CS#-high cycles before next request is accepted (0..255).
REQ-005 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  1  host request, sampled only in IDLE.
REQ-008 SHALL have port req_write  input  1  1=write cycle, 0=read cycle.
REQ-009 SHALL have port req_address  input  2  target register address.
REQ-010 SHALL have port req_data  input  8  write data.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port read_data  output  8  data captured by last read.
REQ-014 SHALL have port chip_select_n  output  1  peripheral select, active low.
REQ-015 SHALL have ports read_enable_n / write_enable_n  output  1 each  strobes, active low.
REQ-016 SHALL have port address  output  2  peripheral register address.
REQ-017 SHALL have port data_bus_out  output  8  write data to peripheral.
REQ-018 SHALL have port data_bus_out_enable  output  1  write data drive enable.
REQ-019 SHALL have port data_bus_in  input  8  read data from peripheral.

Function
REQ-020 SHALL implement states IDLE, SETUP, STROBE, HOLD, RECOVER; all bus outputs registered (no combinational path input->bus output).
REQ-021 IDLE with req=1 at an edge SHALL latch req_write/req_address/req_data and enter SETUP (or STROBE if SETUP_CYCLES=0); req in any other state SHALL be ignored.
REQ-022 SETUP: chip_select_n=0, address=latched, both strobes=1, for SETUP_CYCLES cycles.
REQ-023 STROBE: chip_select_n=0, read_enable_n=0 (read) or write_enable_n=0 (write), for PULSE_CYCLES cycles; never both strobes low.
REQ-024 Read: data_bus_in SHALL be captured into read_data at the edge ending the last STROBE cycle.
REQ-025 HOLD: strobes=1, chip_select_n=0, address and data_bus_out unchanged, for HOLD_CYCLES cycles.
REQ-026 done SHALL be 1 for exactly the first cycle after HOLD (in RECOVER, or IDLE if RECOVERY_CYCLES=0); read_data valid from that cycle until next read completes; writes SHALL NOT alter read_data.
REQ-027 RECOVER: chip_select_n=1, strobes=1, for RECOVERY_CYCLES cycles, then IDLE.
REQ-028 data_bus_out_enable=1 from SETUP entry through last HOLD cycle of write cycles only; 0 for reads and IDLE/RECOVER.
REQ-029 address and data_bus_out SHALL hold their last values outside a cycle.
REQ-030 Phase counter 8 bits, unsigned, reloaded at each state entry; no wrap at 255.
REQ-031 busy SHALL be 0 only in IDLE; req accepted at the edge ending a cycle where done=1 and RECOVERY_CYCLES=0 SHALL start a new cycle back-to-back.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, chip_select_n=1, read_enable_n=1, write_enable_n=1, data_bus_out_enable=0, busy=0, done=0, address=0, data_bus_out=0, read_data=0.
REQ-033 Reset asserted mid-cycle SHALL abort the cycle with no done pulse and no read_data update; first req after release SHALL be accepted normally.

Verification
REQ-034 Defaults, write addr 2'b11 data 8'h80 accepted edge E0 -> CS# low [E0,E4), WR# low [E1,E3), done=1 [E4,E5), busy=0 from E5.
REQ-035 Defaults, read addr 2'b01, data_bus_in=8'h5A at E3 and 8'hFF otherwise -> RD# low [E1,E3), read_data=8'h5A from E3, data_bus_out_enable stays 0.
REQ-036 SETUP_CYCLES=0, RECOVERY_CYCLES=0, req held high -> back-to-back writes, strobe low at E0, done every PULSE+HOLD cycles, CS# never high between cycles.
REQ-037 req pulsed during STROBE of an active cycle -> ignored, exactly one done, latched address/data unchanged.
REQ-038 reset_n low during STROBE of a read -> strobes/CS# high asynchronously, no done, read_data stays 8'h00.
